// File: rtl/morse_key_capture_if.sv
// Symbol bus between the key-capture stage and the ASCII lookup stage.
// The capture stage drives it (master) and the lookup stage reads it (slave).
interface morse_key_capture_if;
    logic [9:0] morse_out;
    logic       morse_valid;
    logic       overflow;
    logic [2:0] elem_count;

    modport master (
        output morse_out,
        output morse_valid,
        output overflow,
        output elem_count
    );

    modport slave (
        input morse_out,
        input morse_valid,
        input overflow,
        input elem_count
    );
endinterface

// File: rtl/morse_key_capture.sv
// Times a single telegraph key, classifies each press as dot or dash and
// groups elements into a left-justified 10-bit letter with a one-cycle strobe.
module morse_key_capture #(
    parameter int CNT_W            = 26,
    parameter int MIN_PRESS_TICKS  = 500000,
    parameter int DOT_MAX_TICKS    = 12500000,
    parameter int LETTER_GAP_TICKS = 37500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_in,
    morse_key_capture_if.master sym_if
);

    localparam int               NUM_SLOTS = 5;
    localparam logic [9:0]       EMPTY_SYM = 10'b0101010101;
    localparam logic [1:0]       ELEM_DOT  = 2'b10;
    localparam logic [1:0]       ELEM_DASH = 2'b11;
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PRESS_TICKS);
    localparam logic [CNT_W-1:0] DOT_C     = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP
    } state_t;

    logic             r_key_meta;
    logic             r_key_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_press_cnt;
    logic [CNT_W-1:0] w_press_cnt_next;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] w_gap_cnt_next;
    logic [9:0]       r_buf;
    logic [9:0]       w_buf_next;
    logic [2:0]       r_elem_cnt;
    logic [2:0]       w_elem_cnt_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [9:0]       r_morse_out;
    logic [9:0]       w_morse_out_next;
    logic             r_morse_valid;
    logic             w_morse_valid_next;
    logic             r_overflow;
    logic             w_overflow_next;

    logic [CNT_W-1:0] w_press_inc;
    logic [CNT_W-1:0] w_gap_inc;
    logic             w_is_glitch;
    logic [1:0]       w_elem;
    logic             w_buf_full;
    logic [9:0]       w_buf_app;

    // Two-flop synchronizer; key_in has no relation to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
        end else begin
            r_key_meta <= key_in;
            r_key_s    <= r_key_meta;
        end
    end

    assign w_press_inc = (r_press_cnt == CNT_MAX) ? r_press_cnt : r_press_cnt + CNT_ONE;
    assign w_gap_inc   = (r_gap_cnt == CNT_MAX) ? r_gap_cnt : r_gap_cnt + CNT_ONE;
    assign w_is_glitch = (r_press_cnt < MIN_C);
    assign w_elem      = (r_press_cnt <= DOT_C) ? ELEM_DOT : ELEM_DASH;
    assign w_buf_full  = (r_elem_cnt == 3'(NUM_SLOTS));

    // Buffer with the new element dropped into slot elem_count; slot 0 is [9:8].
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_buf_app[9-2*gi -: 2] = (r_elem_cnt == 3'(gi)) ? w_elem
                                                                   : r_buf[9-2*gi -: 2];
        end
    endgenerate

    always_comb begin
        w_state_next       = r_state;
        w_press_cnt_next   = r_press_cnt;
        w_gap_cnt_next     = r_gap_cnt;
        w_buf_next         = r_buf;
        w_elem_cnt_next    = r_elem_cnt;
        w_ovf_next         = r_ovf;
        w_morse_out_next   = r_morse_out;
        w_morse_valid_next = 1'b0;
        w_overflow_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_key_s) begin
                    w_press_cnt_next = CNT_ONE;
                    w_state_next     = ST_PRESS;
                end
            end

            ST_PRESS: begin
                if (r_key_s) begin
                    w_press_cnt_next = w_press_inc;
                end else if (w_is_glitch) begin
                    // A glitch inside a letter restarts the gap timer.
                    if (r_elem_cnt == 3'd0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next   = ST_GAP;
                        w_gap_cnt_next = CNT_ONE;
                    end
                end else begin
                    if (w_buf_full) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_buf_next      = w_buf_app;
                        w_elem_cnt_next = r_elem_cnt + 3'd1;
                    end
                    w_state_next   = ST_GAP;
                    w_gap_cnt_next = CNT_ONE;
                end
            end

            ST_GAP: begin
                if (r_key_s) begin
                    w_press_cnt_next = CNT_ONE;
                    w_state_next     = ST_PRESS;
                end else if (r_gap_cnt == GAP_C) begin
                    w_morse_valid_next = 1'b1;
                    w_morse_out_next   = r_ovf ? EMPTY_SYM : r_buf;
                    w_overflow_next    = r_ovf;
                    w_buf_next         = EMPTY_SYM;
                    w_elem_cnt_next    = 3'd0;
                    w_ovf_next         = 1'b0;
                    w_state_next       = ST_IDLE;
                end else begin
                    w_gap_cnt_next = w_gap_inc;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_press_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_buf         <= EMPTY_SYM;
            r_elem_cnt    <= 3'd0;
            r_ovf         <= 1'b0;
            r_morse_out   <= EMPTY_SYM;
            r_morse_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_press_cnt   <= w_press_cnt_next;
            r_gap_cnt     <= w_gap_cnt_next;
            r_buf         <= w_buf_next;
            r_elem_cnt    <= w_elem_cnt_next;
            r_ovf         <= w_ovf_next;
            r_morse_out   <= w_morse_out_next;
            r_morse_valid <= w_morse_valid_next;
            r_overflow    <= w_overflow_next;
        end
    end

    assign sym_if.morse_out   = r_morse_out;
    assign sym_if.morse_valid = r_morse_valid;
    assign sym_if.overflow    = r_overflow;
    assign sym_if.elem_count  = r_elem_cnt;

endmodule
